// File: rtl/router_pkg.sv
// router_pkg: shared FSM states, parity seeds and length-field width for the packet register
package router_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
  localparam logic [63:0] PARITY_SEED_EVEN = '0;
  localparam logic [63:0] PARITY_SEED_ODD = '1;
  function automatic int len_width(input int width, input int addr_bits);
    return width - addr_bits;
  endfunction
endpackage

// File: rtl/router_skid_buf.sv
// router_skid_buf: circular FIFO buffer with registered occupancy count and synchronous flush
module router_skid_buf #(
  parameter int WIDTH = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic [WIDTH-1:0]                din,
  output logic [WIDTH-1:0]                dout,
  output logic [$clog2(SKID_DEPTH+1)-1:0] count,
  output logic                            empty
);
  localparam int PW = SKID_DEPTH > 1 ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(SKID_DEPTH - 1);
  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [PW-1:0] rd, wr;
  logic full, do_push, do_pop;
  assign full = count == CW'(SKID_DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clock) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr == LAST ? '0 : wr + 1'b1;
      end
      if (do_pop) rd <= rd == LAST ? '0 : rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/router_pkt_reg.sv
// router_pkt_reg: packet tracker with seeded XOR parity, length check and skid-buffered byte forwarding
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR_BITS = 2,
  parameter int SKID_DEPTH = 2,
  parameter int PARITY_MODE = 0,
  parameter int CHECK_LEN = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 in_strobe,
  output logic                 in_ready,
  input  logic                 fifo_full,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic [ADDR_BITS-1:0] dest,
  output logic                 dest_valid,
  output logic                 busy,
  output logic                 parity_done,
  output logic                 err,
  output logic                 len_err
);
  localparam int LW = len_width(WIDTH, ADDR_BITS);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [WIDTH-1:0] SEED = WIDTH'(PARITY_MODE != 0 ? PARITY_SEED_ODD : PARITY_SEED_EVEN);
  state_t state, state_n;
  logic [WIDTH-1:0] acc, par;
  logic [LW-1:0] cnt, len;
  logic [CW-1:0] count;
  logic empty, accept, pop, header;
  assign in_ready = count < CW'(SKID_DEPTH);
  assign accept = in_strobe && in_ready;
  assign dout_valid = !empty;
  assign pop = dout_valid && !fifo_full;
  assign busy = state != IDLE || !empty;
  assign header = state == IDLE && accept && pkt_valid;
  router_skid_buf #(.WIDTH(WIDTH), .SKID_DEPTH(SKID_DEPTH)) u_buf (
    .clock(clock), .reset(reset), .push(accept), .pop(pop), .din(data_in),
    .dout(dout), .count(count), .empty(empty)
  );
  always_comb begin
    state_n = state == CHECK ? IDLE
            : header ? PAYLOAD
            : (state == PAYLOAD && accept && !pkt_valid) ? CHECK : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      acc <= SEED;
      par <= '0;
      cnt <= '0;
      len <= '0;
      dest <= '0;
      dest_valid <= 1'b0;
      parity_done <= 1'b0;
      err <= 1'b0;
      len_err <= 1'b0;
    end else begin
      state <= state_n;
      dest_valid <= 1'b0;
      if (header) begin
        dest <= data_in[ADDR_BITS-1:0];
        len <= data_in[WIDTH-1:ADDR_BITS];
        acc <= SEED ^ data_in;
        cnt <= '0;
        dest_valid <= 1'b1;
        parity_done <= 1'b0;
        err <= 1'b0;
        len_err <= 1'b0;
      end
      if (state == PAYLOAD && accept && pkt_valid) begin
        acc <= acc ^ data_in;
        cnt <= &cnt ? cnt : cnt + 1'b1;
      end
      if (state == PAYLOAD && accept && !pkt_valid) par <= data_in;
      if (state == CHECK) begin
        parity_done <= 1'b1;
        err <= acc != par;
        len_err <= (CHECK_LEN != 0) && (cnt != len || len == '0);
      end
    end
  end
endmodule

// File: doc/router_pkt_reg.md
Name: router_pkt_reg

Overview:
Parametrised successor of the router's packet register/parity stage. It absorbs a packet byte stream (header, payload, parity byte) and forwards every byte to the destination FIFO through an internal skid buffer of configurable depth, replacing the single full-state holding byte. It tracks the packet with its own state machine, so no external FSM state strobes are needed. It computes seeded XOR parity, checks payload length against the header, and reports dest, parity_done, err and len_err.

Parameters:
WIDTH, 8, byte width of data_in/dout.
ADDR_BITS, 2, header LSBs carrying the destination address; the header MSBs [WIDTH-1:ADDR_BITS] carry payload length L.
SKID_DEPTH, 2, skid buffer entries (>=1).
PARITY_MODE, 0, 0 = parity seed all-zeros; 1 = seed all-ones.
CHECK_LEN, 1, 1 = length check enabled; 0 = len_err tied 0.

Ports:
clock  in  1  sole clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
pkt_valid  in  1  high for header and payload bytes, low for the parity byte.
data_in  in  WIDTH  input byte.
in_strobe  in  1  upstream presents a byte this cycle.
in_ready  out  1  byte accepted when in_strobe && in_ready.
fifo_full  in  1  downstream backpressure.
dout  out  WIDTH  head of the skid buffer.
dout_valid  out  1  dout holds a byte; consumed when dout_valid && !fifo_full.
dest  out  ADDR_BITS  destination of the current/last packet, registered.
dest_valid  out  1  one-cycle pulse on header acceptance.
busy  out  1  FSM not in IDLE, or buffer non-empty.
parity_done  out  1  level; set at packet end, cleared on next header acceptance.
err  out  1  parity mismatch, valid while parity_done.
len_err  out  1  payload count != L (or L==0), valid while parity_done.

Behaviour:
- Reset (any cycle, including mid-packet): FSM->IDLE, buffer flushed, all outputs 0, parity accumulator = seed, payload count 0, in_ready=1 on the first cycle after reset.
- in_ready = (buffer count < SKID_DEPTH), registered-count based, no combinational path from fifo_full.
- Buffer: FIFO order. Every accepted byte is pushed, including header and parity bytes. Latency: a byte accepted into an empty buffer appears on dout with dout_valid the next cycle. A push and a pop in the same cycle leave the count unchanged. A pop happens only when dout_valid is high.
- FSM states: IDLE, PAYLOAD, CHECK.
- IDLE: an accepted byte with pkt_valid=1 is the header.
  - Latch dest and L.
  - Accumulator = seed ^ header; count = 0.
  - Pulse dest_valid; clear parity_done, err and len_err in the same cycle.
  - Go to PAYLOAD.
  - An accepted byte with pkt_valid=0 in IDLE is pushed but otherwise ignored (stray byte).
- PAYLOAD:
  - Accepted byte with pkt_valid=1: accumulator ^= byte; count++, saturating at all-ones.
  - Accepted byte with pkt_valid=0: this is the parity byte. Latch it and go to CHECK.
- CHECK (one cycle): parity_done<=1; err<=(accumulator != parity byte); len_err<=CHECK_LEN && (count != L || L==0). Go to IDLE.
- A header accepted in the cycle right after CHECK is legal: clears take effect in that cycle.
- With in_strobe low or in_ready low, state, accumulator and count are held. A byte stalled by backpressure is never counted twice.
- err and len_err hold until the next header or reset.
- The buffer drains independently of FSM state, and busy stays high until the buffer is empty.

Decomposition:
- Package router_pkg: FSM state enum (IDLE/PAYLOAD/CHECK); localparams PARITY_SEED_EVEN='0 and PARITY_SEED_ODD='1; width function for the length field (WIDTH-ADDR_BITS).
- Sub-module router_skid_buf (WIDTH, SKID_DEPTH): circular buffer with push/pop, count, full/empty, and synchronous flush on reset.
- The top holds the FSM, accumulator, counter and flags.

Test Plan:
1. Good packet, default parameters, fifo_full=0: header 0x0D (L=3, dest=1), payload 0x11,0x22,0x33, parity 0x0D -> dest_valid pulse with dest=1; dout sequence 0D,11,22,33,0D, each one cycle after acceptance; parity_done=1, err=0, len_err=0.
2. Bad parity: same packet with parity 0x0C -> err=1, len_err=0. The next header 0x05 clears parity_done and err in its acceptance cycle.
3. Length mismatch: header 0x0D, payload 0x11,0x22, parity 0x3E -> err=0, len_err=1. Repeat with CHECK_LEN=0 -> len_err=0.
4. Backpressure, SKID_DEPTH=2: fifo_full held high for 4 cycles during payload with in_strobe held -> in_ready falls after 2 buffered bytes; no byte lost or duplicated; order preserved; parity result identical to scenario 1.
5. Reset mid-packet after 2 payload bytes with 1 byte buffered -> next cycle dout_valid=0, parity_done=0, in_ready=1. A fresh good packet then passes as in scenario 1.
6. PARITY_MODE=1: scenario 1 packet with parity 0xF2 -> err=0; with parity 0x0D -> err=1.
